// File: rtl/egress_packet_merger_pkg.sv
// Shared definitions for the egress packet merger: bus widths, source IDs and FSM encodings.
package egress_packet_merger_pkg;

    localparam int PKT_HEAD_BUS_WIDTH = 16;
    localparam int PKT_DATA_BUS_WIDTH = 32;

    typedef logic src_t;
    localparam src_t SRC_REQ  = 1'b0;
    localparam src_t SRC_RESP = 1'b1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOCK_REQ  = 2'd1;
    localparam logic [1:0] ST_LOCK_RESP = 2'd2;

    function automatic logic [1:0] lock_state(input src_t s);
        return (s == SRC_RESP) ? ST_LOCK_RESP : ST_LOCK_REQ;
    endfunction

endpackage

// File: rtl/egress_packet_merger_if.sv
// Packet beat bundle: valid/ready handshake carrying head, data and start/last framing.
interface egress_packet_merger_if #(
    parameter int HEAD_W = egress_packet_merger_pkg::PKT_HEAD_BUS_WIDTH,
    parameter int DATA_W = egress_packet_merger_pkg::PKT_DATA_BUS_WIDTH
);
    logic              valid;
    logic [HEAD_W-1:0] head;
    logic [DATA_W-1:0] data;
    logic              start;
    logic              last;
    logic              ready;

    modport master (output valid, head, data, start, last, input ready);
    modport slave  (input valid, head, data, start, last, output ready);
endinterface

// File: rtl/egress_packet_merger_skid.sv
// Two-entry FIFO with registered output; in_ready depends only on occupancy, never on out_ready.
module egress_packet_merger_skid #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    input  logic             out_ready
);
    logic [WIDTH-1:0] ent0, ent1;
    logic [1:0]       cnt;
    logic             do_push, do_pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign dout      = ent0;
    assign do_push   = push & in_ready;
    assign do_pop    = out_ready & out_valid;

    // ent0 is always the head of the queue and drives the output directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/egress_packet_merger.sv
// Merges request- and response-engine packet streams into one egress stream. Arbitration is
// per packet with round-robin on ties; the output is registered through a 2-entry skid buffer.
module egress_packet_merger
    import egress_packet_merger_pkg::*;
#(
    parameter int HEAD_W = PKT_HEAD_BUS_WIDTH,
    parameter int DATA_W = PKT_DATA_BUS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    egress_packet_merger_if.slave  req_trans_pkt,
    egress_packet_merger_if.slave  resp_trans_pkt,
    egress_packet_merger_if.master egress_packet,
    output logic                   merge_proto_err
);
    localparam int BEAT_W = HEAD_W + DATA_W + 2;

    logic [1:0]        state;
    src_t              rr_last, grant, src;
    logic              free, sel_req, sel_resp, acc, push;
    logic [HEAD_W-1:0] b_head;
    logic [DATA_W-1:0] b_data;
    logic              b_start, b_last;
    logic [BEAT_W-1:0] buf_out;

    always_comb begin
        grant = SRC_REQ;
        if (req_trans_pkt.valid && resp_trans_pkt.valid) grant = ~rr_last;
        else if (resp_trans_pkt.valid)                    grant = SRC_RESP;
    end

    // In IDLE the winner is selected combinationally so its start beat goes through with no bubble.
    assign sel_req  = (state == ST_IDLE) ? (req_trans_pkt.valid && grant == SRC_REQ)
                                         : (state == ST_LOCK_REQ);
    assign sel_resp = (state == ST_IDLE) ? (resp_trans_pkt.valid && grant == SRC_RESP)
                                         : (state == ST_LOCK_RESP);

    assign req_trans_pkt.ready  = ~rst & free & sel_req;
    assign resp_trans_pkt.ready = ~rst & free & sel_resp;

    assign src     = sel_resp ? SRC_RESP : SRC_REQ;
    assign b_head  = sel_resp ? resp_trans_pkt.head  : req_trans_pkt.head;
    assign b_data  = sel_resp ? resp_trans_pkt.data  : req_trans_pkt.data;
    assign b_start = sel_resp ? resp_trans_pkt.start : req_trans_pkt.start;
    assign b_last  = sel_resp ? resp_trans_pkt.last  : req_trans_pkt.last;

    assign acc  = (req_trans_pkt.valid & req_trans_pkt.ready) |
                  (resp_trans_pkt.valid & resp_trans_pkt.ready);
    // A headless beat arriving in IDLE is swallowed so the engine cannot wedge.
    assign push = acc & (b_start | (state != ST_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            rr_last         <= SRC_RESP;
            merge_proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc) begin
                        if (!b_start)    merge_proto_err <= 1'b1;
                        else if (b_last) rr_last <= src;
                        else             state <= lock_state(src);
                    end
                end
                ST_LOCK_REQ, ST_LOCK_RESP: begin
                    if (acc) begin
                        if (b_start) merge_proto_err <= 1'b1;
                        if (b_last) begin
                            state   <= ST_IDLE;
                            rr_last <= src;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    egress_packet_merger_skid #(.WIDTH(BEAT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       ({b_head, b_data, b_start, b_last}),
        .in_ready  (free),
        .out_valid (egress_packet.valid),
        .dout      (buf_out),
        .out_ready (egress_packet.ready)
    );

    assign {egress_packet.head, egress_packet.data, egress_packet.start, egress_packet.last} = buf_out;

endmodule
